// File: rtl/as1_pkg.sv
// Shared constants and types for the as1 registered 4-input Boolean function unit.
package as1_pkg;

    localparam logic [15:0] AS1_PRIME_TT = 16'h28AC;
    localparam int          AS1_IDX_W    = 4;

    typedef logic [AS1_IDX_W-1:0] as1_idx_t;

endpackage

// File: rtl/as1_sync.sv
// One-bit reset-to-0 synchronizer chain; STAGES=0 degenerates to a straight wire.
module as1_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    if (STAGES == 0) begin : g_bypass
        assign o_q = i_d;
    end else begin : g_chain
        logic [STAGES-1:0] r_chain;

        // Shift the raw input through the flop chain, cleared asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_chain <= {STAGES{1'b0}};
            end else begin
                r_chain[0] <= i_d;
                for (int i = 1; i < STAGES; i++) begin
                    r_chain[i] <= r_chain[i-1];
                end
            end
        end

        assign o_q = r_chain[STAGES-1];
    end

endmodule

// File: rtl/as1.sv
// Registered truth-table lookup on four independently synchronized inputs.
module as1
    import as1_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = AS1_PRIME_TT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    output logic out
);

    if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("as1: SYNC_STAGES must be in 0..4");
    end

    as1_idx_t w_raw;
    as1_idx_t w_idx;
    logic     w_out_next;
    logic     r_out;

    assign w_raw = {in4, in3, in2, in1};

    for (genvar g = 0; g < AS1_IDX_W; g++) begin : g_sync
        as1_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .i_d  (w_raw[g]),
            .o_q  (w_idx[g])
        );
    end

    // An X index reads back as X, so unknown inputs are deliberately not masked.
    assign w_out_next = TRUTH_TABLE[w_idx];

    // Output register: the only place the result changes, hence glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_as1.sv
// Randomized and directed bench for as1, checked against a latency-based reference model.
module tb_as1;

    logic clk = 1'b0;
    logic rst_n;
    logic in1, in2, in3, in4;
    logic out_d2, out_d0, out_and;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [15:0] TT_PRIME = 16'h28AC;
    localparam logic [15:0] TT_AND   = 16'h8000;

    // hist[k] = index presented at the edge k edges ago (0 = most recent edge)
    logic [3:0] hist [0:4];
    logic [3:0] cur_idx;

    int sweep_exp [16] = '{0,0,1,1,0,1,0,1,0,0,0,1,0,1,0,0};

    always #5 clk = ~clk;

    as1 #(.TRUTH_TABLE(TT_PRIME), .SYNC_STAGES(2)) u_dut_d2 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out(out_d2));
    as1 #(.TRUTH_TABLE(TT_PRIME), .SYNC_STAGES(0)) u_dut_d0 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out(out_d0));
    as1 #(.TRUTH_TABLE(TT_AND), .SYNC_STAGES(2)) u_dut_and (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out(out_and));

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic tt_lookup(input logic [15:0] tt, input logic [3:0] idx);
        logic [15:0] t;
        t = tt;
        return t[idx];
    endfunction

    task automatic set_idx(input logic [3:0] idx);
        cur_idx = idx;
        {in4, in3, in2, in1} = idx;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 5; i++) hist[i] = 4'd0;
    endtask

    task automatic check_model(input string tag);
        check_bit({tag, "_s2"},  out_d2,  tt_lookup(TT_PRIME, hist[2]));
        check_bit({tag, "_s0"},  out_d0,  tt_lookup(TT_PRIME, hist[0]));
        check_bit({tag, "_and"}, out_and, tt_lookup(TT_AND,   hist[2]));
    endtask

    // Drive idx, take one edge, update model, then check just after the edge and late in the cycle.
    task automatic step(input logic [3:0] idx, input string tag);
        set_idx(idx);
        @(posedge clk);
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = cur_idx;
        #1;
        check_model(tag);
        #6;
        check_model({tag, "_hold"});
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_idx(4'b1111);
        clear_hist();

        // Async reset with inputs all ones and the clock running
        #2 rst_n = 1'b0;
        #1;
        check_bit("rst_now_s2", out_d2, 1'b0);
        check_bit("rst_now_s0", out_d0, 1'b0);
        check_bit("rst_now_and", out_and, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_bit("rst_hold_s2", out_d2, 1'b0);
            check_bit("rst_hold_s0", out_d0, 1'b0);
            check_bit("rst_hold_and", out_and, 1'b0);
        end
        set_idx(4'b0000);
        rst_n = 1'b1;
        clear_hist();

        for (int c = 0; c < 5; c++) step(4'd0, "idle");

        // Latency: 0000 -> 0011 rises on exactly the 3rd edge (1st for zero stages)
        step(4'd3, "lat1");
        check_bit("lat_e1_s2", out_d2, 1'b0);
        check_bit("lat_e1_s0", out_d0, 1'b1);
        step(4'd3, "lat2");
        check_bit("lat_e2_s2", out_d2, 1'b0);
        step(4'd3, "lat3");
        check_bit("lat_e3_s2", out_d2, 1'b1);

        // Exhaustive sweep, 5 cycles per index
        for (int idx = 0; idx < 16; idx++) begin
            for (int c = 0; c < 5; c++) begin
                step(4'(idx), "sweep");
                if (c >= 2) begin
                    check_bit("sweep_prime", out_d2, sweep_exp[idx] != 0);
                    check_bit("sweep_and", out_and, idx == 15);
                end
            end
        end

        // Staggered inputs: idx 1,3,7,15 one cycle apart
        for (int c = 0; c < 5; c++) step(4'd0, "stag_pre");
        step(4'd1, "stag");
        step(4'd3, "stag");
        step(4'd7, "stag");
        check_bit("stag_e3", out_d2, 1'b0);
        step(4'd15, "stag");
        check_bit("stag_e4", out_d2, 1'b1);
        step(4'd15, "stag");
        check_bit("stag_e5", out_d2, 1'b1);
        step(4'd15, "stag");
        check_bit("stag_e6", out_d2, 1'b0);
        for (int c = 0; c < 3; c++) step(4'd15, "stag_post");

        // Mid-operation half-cycle reset while out=1 at idx 13
        for (int c = 0; c < 5; c++) step(4'd13, "pre_mid");
        check_bit("mid_before", out_d2, 1'b1);
        @(posedge clk);
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = cur_idx;
        #2 rst_n = 1'b0;
        #1;
        check_bit("mid_rst_s2", out_d2, 1'b0);
        check_bit("mid_rst_s0", out_d0, 1'b0);
        #2 rst_n = 1'b1;
        clear_hist();
        #3;
        step(4'd13, "mid_r1");
        check_bit("mid_r1_s2", out_d2, 1'b0);
        step(4'd13, "mid_r2");
        check_bit("mid_r2_s2", out_d2, 1'b0);
        step(4'd13, "mid_r3");
        check_bit("mid_r3_s2", out_d2, 1'b1);

        // Randomized stimulus with random hold lengths
        for (int n = 0; n < 150; n++) begin
            logic [3:0] r_idx;
            int hold;
            r_idx = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) step(r_idx, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
